// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: pipeline register for a control bundle between CPU stages.
// A 2-entry skid buffer (main + skid) sits behind a valid/ready handshake, so
// in_ready depends only on registered state plus the flush/lock controls, and
// no bundle is dropped under backpressure.
//
// Priority per clock edge: reset > flush > lock > normal handshake.
//
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous active-low reset
//   flush      discard all held bundles (overrides lock)
//   lock       freeze the stage, no transfers
//   in_valid   upstream bundle valid
//   in_ready   stage can accept
//   in_data    upstream bundle
//   out_valid  bundle available downstream
//   out_ready  downstream accepts
//   out_data   bundle to next stage (always the main register)
//   stall_cnt  saturating stall counter, only with CTRL_PIPE_STAGE_STATS_EN
//
// Build option: define CTRL_PIPE_STAGE_STATS_EN to add the stall_cnt port.
module ctrl_pipe_stage #(
    parameter int unsigned       WIDTH  = 32,
    parameter logic [WIDTH-1:0]  BUBBLE = {WIDTH{1'b0}},
    parameter int unsigned       STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              lock,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data
`ifdef CTRL_PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    // Handshakes are masked by flush/lock so no transfer happens on those edges.
    assign in_ready  = (state_q != StTwo) && !lock && !flush;
    assign out_valid = (state_q != StEmpty) && !lock && !flush;
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StEmpty;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else if (!lock) begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new bundle behind main.
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                        main_d  = BUBBLE;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

`ifdef CTRL_PIPE_STAGE_STATS_EN
    logic [STAT_W-1:0] stall_q;
    logic              stall_inc;

    // Counts cycles a held bundle cannot leave; flush does not clear it.
    assign stall_inc = (state_q != StEmpty) && (lock || !out_ready) && !flush;
    assign stall_cnt = stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != {STAT_W{1'b1}})) begin
            stall_q <= stall_q + STAT_W'(1);
        end
    end
`else
    logic [STAT_W-1:0] unused_stat_w;
    assign unused_stat_w = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Scoreboard bench for ctrl_pipe_stage: accepted bundles are pushed to a
// queue; a monitor pops and compares on every output handshake.
module tb_ctrl_pipe_stage;

    localparam int unsigned WIDTH = 32;
    localparam logic [WIDTH-1:0] BUB = '0;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             lock = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
`ifdef CTRL_PIPE_STAGE_STATS_EN
    logic [3:0]       stall_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [WIDTH-1:0] sb[$];

    always #5 clk = ~clk;

    ctrl_pipe_stage #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUB),
        .STAT_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .lock      (lock),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef CTRL_PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a bundle until accepted (bounded); optionally check out_valid
    // at the accepting sample point.
    task automatic send(input logic [WIDTH-1:0] d, input bit chk_ov);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: data %h never accepted, in_ready %0b required 1",
                     d, in_ready);
        end else begin
            sb.push_back(d);
            if (chk_ov) chk("stream_out_valid", {31'b0, out_valid}, 32'd1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: compare every downstream handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got %h required no output", out_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = sb.pop_front();
                if (out_data !== e) begin
                    fails++;
                    $display("FAIL sb_data: got %h required %h", out_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset / idle
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, BUB);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef CTRL_PIPE_STAGE_STATS_EN
        chk("reset_stall_cnt", {28'b0, stall_cnt}, 32'd0);
`endif
        tick();

        // Streaming, one per cycle
        out_ready = 1'b1;
        send(32'h11, 1'b0);
        send(32'h22, 1'b1);
        send(32'h33, 1'b1);
        @(negedge clk);
        chk("stream_last_valid", {31'b0, out_valid}, 32'd1);
        tick();
        tick();
        chk("stream_drained", {31'b0, out_valid}, 32'd0);

        // Backpressure: two accepted, third held off
        out_ready = 1'b0;
        send(32'hA1, 1'b0);
        send(32'hA2, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hA3;
        @(negedge clk);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_hold_head", out_data, 32'hA1);
        tick();
        @(negedge clk);
        chk("bp_in_ready_still_low", {31'b0, in_ready}, 32'd0);
        tick();
        out_ready = 1'b1;
        send(32'hA3, 1'b0);
        tick();
        tick();

        // Flush from full state, with lock and in_valid both asserted
        out_ready = 1'b0;
        send(32'hB1, 1'b0);
        send(32'hB2, 1'b0);
        flush     = 1'b1;
        lock      = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hEE;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        sb.delete();
        tick();
        flush    = 1'b0;
        lock     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_flush_out_data", out_data, BUB);
        chk("post_flush_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        tick();

        // Lock holding one bundle
        out_ready = 1'b0;
        send(32'hC1, 1'b0);
        lock      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lock_out_valid", {31'b0, out_valid}, 32'd0);
            chk("lock_in_ready", {31'b0, in_ready}, 32'd0);
            chk("lock_main", out_data, 32'hC1);
            tick();
        end
        lock = 1'b0;
        tick();
        @(negedge clk);
        chk("lock_delivered_once", {31'b0, out_valid}, 32'd0);
        tick();

`ifdef CTRL_PIPE_STAGE_STATS_EN
        // Stall counter saturation, survives flush, cleared by reset
        out_ready = 1'b0;
        send(32'hE1, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        chk("stat_saturate", {28'b0, stall_cnt}, 32'd15);
        flush = 1'b1;
        sb.delete();
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("stat_after_flush", {28'b0, stall_cnt}, 32'd15);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("stat_after_reset", {28'b0, stall_cnt}, 32'd0);
        tick();
`endif

        tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_stage.md
Name: ctrl_pipe_stage

Overview:
- Parametrised pipeline stage register for control bundles between CPU stages; successor to fixed-field ID/EX control registers.
- Adds a valid/ready handshake with a 2-entry skid buffer, so upstream ready is registered-state-only and the stage never drops a bundle under backpressure.
- Flush and lock semantics match existing stage registers; bubble value is a parameter instead of hard-wired per-field "unused" codes.

Parameters:
- WIDTH, 32, bit width of the concatenated control bundle.
- BUBBLE, {WIDTH{1'b0}}, value driven/stored when the stage is empty or flushed (NOP control encoding).
- STAT_W, 16, width of the stall counter (optional feature only).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 at posedge resets).
- flush  in  1  discard all held bundles.
- lock  in  1  freeze stage (stall from hazard unit).
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept.
- in_data  in  WIDTH  upstream bundle.
- out_valid  out  1  bundle available downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  bundle to next stage.
- stall_cnt  out  STAT_W  only with CTRL_PIPE_STAGE_STATS_EN.

Behaviour:
- Storage: main reg (drives out_data), skid reg, state {EMPTY, ONE, TWO}.
- Reset (rst==0 at posedge): state=EMPTY, main=skid=BUBBLE; outputs afterwards: out_valid=0, out_data=BUBBLE, in_ready=1 (if lock=0, flush=0).
- in_ready = (state!=TWO) & !lock & !flush. out_valid = (state!=EMPTY) & !lock & !flush. out_data = main always.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Priority per edge: reset > flush > lock > normal.
- flush=1: state=EMPTY, main=skid=BUBBLE; no transfer either side that cycle (both handshakes masked). Overrides lock.
- lock=1 (no flush): all state held; no transfers.
- EMPTY: in_fire -> ONE, main=in_data.
- ONE: in_fire&out_fire -> ONE, main=in_data; in_fire&!out_fire -> TWO, skid=in_data; !in_fire&out_fire -> EMPTY, main=BUBBLE; neither -> hold.
- TWO: out_fire -> ONE, main=skid, skid=BUBBLE; else hold. in_ready=0, so no input.
- Latency: 1 cycle in_data -> out_data when empty. Throughput 1/cycle with out_ready=1.
- Ordering strictly FIFO; no bundle duplicated or lost except by flush.
- Reset mid-operation: held bundles discarded identically to flush.

Optional Feature:
- Macro CTRL_PIPE_STAGE_STATS_EN.
- Defined: port stall_cnt present. Increments by 1 each cycle where state!=EMPTY and (lock | !out_ready) and !flush. Saturates at all-ones. Cleared only by reset; flush does not clear it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then rst=1 -> out_valid=0, out_data=BUBBLE, in_ready=1.
- Streaming: WIDTH=32, out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, out_valid continuous.
- Backpressure: out_ready=0, send 0xA1,0xA2 -> in_ready drops after 2nd accept. Raising out_ready -> 0xA1 then 0xA2, nothing lost; a 3rd input is held off until in_ready=1.
- Flush: state TWO (0xB1,0xB2 held), pulse flush with lock=1 and in_valid=1 -> next cycle out_valid=0, out_data=BUBBLE, no input accepted during the flush cycle.
- Lock: state ONE (0xC1), lock=1 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, main unchanged. Lock release -> 0xC1 delivered once.
- Stats (macro on, STAT_W=4): hold out_ready=0 with one bundle for 20 cycles -> stall_cnt saturates at 15. Flush -> stall_cnt stays 15. Reset -> 0.
